// File: rtl/ysyx_22051013_clint.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_clint
//
// Core-local interruptor. It serves every load or store that the data-side
// device selector steers into the CLINT window. It holds msip, mtimecmp and a
// prescaled free-running mtime, and it drives the machine timer and software
// interrupt lines. Every accepted request gets a registered response one
// cycle later.
//
// Ports:
//   clk           in   1   clock; all state changes on the rising edge
//   rst           in   1   synchronous reset, active high
//   clint_ena     in   1   request targets the CLINT window
//   core_re       in   1   load request
//   core_we       in   1   store request (wins when core_re is also high)
//   core_mask     in   8   byte-lane write enables
//   core_addr     in  64   byte address (bits [2:0] are ignored)
//   core_data_i   in  64   store data
//   clint_data_o  out 64   load data; zero whenever clint_valid is low
//   clint_valid   out  1   one-cycle response pulse
//   mtip          out  1   machine timer interrupt pending
//   msip          out  1   machine software interrupt pending
// ---------------------------------------------------------------------------
module ysyx_22051013_clint #(
  parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
  parameter int unsigned MTIME_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_ena,
  input  logic        core_re,
  input  logic        core_we,
  input  logic [7:0]  core_mask,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_data_i,
  output logic [63:0] clint_data_o,
  output logic        clint_valid,
  output logic        mtip,
  output logic        msip
);

  localparam logic [63:0] OFF_MSIP     = 64'h0000;
  localparam logic [63:0] OFF_MTIMECMP = 64'h4000;
  localparam logic [63:0] OFF_MTIME    = 64'hBFF8;
  localparam logic [15:0] DIV_LAST     = 16'(MTIME_DIV - 1);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_mtip;
  logic [15:0] r_div_cnt;
  logic        r_valid;
  logic [63:0] r_rdata;

  logic [63:0] w_offset;
  logic [63:0] w_word_off;
  logic        w_accept;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic        w_tick;
  logic [63:0] w_rdata;

  // Per-byte merge of store data into an existing register value.
  function automatic logic [63:0] f_merge(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [7:0]  mask);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Decode on 8-byte words: the low three address bits are masked off.
  assign w_offset   = core_addr - CLINT_BASE;
  assign w_word_off = w_offset & ~64'h7;
  assign w_sel_msip = (w_word_off == OFF_MSIP);
  assign w_sel_cmp  = (w_word_off == OFF_MTIMECMP);
  assign w_sel_time = (w_word_off == OFF_MTIME);

  assign w_accept = clint_ena & (core_re | core_we);
  assign w_tick   = (r_div_cnt == DIV_LAST);

  // Read mux sees the pre-edge register values, so a load never observes the
  // increment that happens on its own accept edge.
  // NOTE: give every always_comb output a default before any branch so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rdata = '0;
    if (w_sel_msip)      w_rdata = {63'd0, r_msip};
    else if (w_sel_cmp)  w_rdata = r_mtimecmp;
    else if (w_sel_time) w_rdata = r_mtime;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_mtip     <= 1'b0;
      r_div_cnt  <= '0;
      r_valid    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_mtip  <= (r_mtime >= r_mtimecmp);
      r_valid <= w_accept;
      // A combined read+write is a store and returns zero data.
      r_rdata <= (w_accept && !core_we) ? w_rdata : '0;

      // An mtime store replaces the increment for that cycle and restarts the
      // prescaler phase.
      if (w_accept && core_we && w_sel_time) begin
        r_mtime   <= f_merge(r_mtime, core_data_i, core_mask);
        r_div_cnt <= '0;
      end else if (w_tick) begin
        r_mtime   <= r_mtime + 64'd1;
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end

      if (w_accept && core_we && w_sel_cmp) begin
        r_mtimecmp <= f_merge(r_mtimecmp, core_data_i, core_mask);
      end

      if (w_accept && core_we && w_sel_msip && core_mask[0]) begin
        r_msip <= core_data_i[0];
      end
    end
  end

  assign clint_data_o = r_rdata;
  assign clint_valid  = r_valid;
  assign mtip         = r_mtip;
  assign msip         = r_msip;

endmodule

// File: tb/tb_ysyx_22051013_clint.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22051013_clint
//
// Directed bench for the CLINT. Two instances share the clock, the reset and
// the request bus: dut1 uses MTIME_DIV=1 and dut4 uses MTIME_DIV=4. Each
// instance has its own clint_ena, so a request reaches only the instance that
// is selected. Inputs change 1 ns after a rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_ysyx_22051013_clint;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE + 64'h0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] A_UNM  = BASE + 64'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena1, ena4;
  logic        re, we;
  logic [7:0]  mask;
  logic [63:0] addr, wdata;

  logic [63:0] data1, data4;
  logic        valid1, valid4, mtip1, mtip4, msip1, msip4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22051013_clint #(.CLINT_BASE(BASE), .MTIME_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .clint_ena(ena1), .core_re(re), .core_we(we),
    .core_mask(mask), .core_addr(addr), .core_data_i(wdata),
    .clint_data_o(data1), .clint_valid(valid1), .mtip(mtip1), .msip(msip1)
  );

  ysyx_22051013_clint #(.CLINT_BASE(BASE), .MTIME_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .clint_ena(ena4), .core_re(re), .core_we(we),
    .core_mask(mask), .core_addr(addr), .core_data_i(wdata),
    .clint_data_o(data4), .clint_valid(valid4), .mtip(mtip4), .msip(msip4)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena1 = 1'b0; ena4 = 1'b0; re = 1'b0; we = 1'b0;
    mask = 8'h00; addr = '0; wdata = '0;
  endtask

  // Drive a single request for the next edge onto one or both instances.
  task automatic drive(input logic e1, input logic e4, input logic r,
                       input logic w, input logic [63:0] a,
                       input logic [7:0] m, input logic [63:0] d);
    ena1 = e1; ena4 = e4; re = r; we = w; addr = a; mask = m; wdata = d;
  endtask

  // Reset for three edges and release right after the third one, so the next
  // edge is the first edge out of reset.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset and idle: every output reads zero while reset is held.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs1", {data1[63:3], valid1, mtip1, msip1}, 64'd0);
      check("rst_outs4", {data4[63:3], valid4, mtip4, msip4}, 64'd0);
    end
    rst = 1'b0;

    // mtime read exactly 10 edges after release (MTIME_DIV=1).
    repeat (10) step();
    drive(1, 0, 1, 0, A_TIME, 8'h00, 0);
    step();
    check("idle_valid", valid1, 1);
    check("idle_mtime", data1, 64'd10);
    idle();
    step();
    check("idle_valid_drop", valid1, 0);
    check("idle_data_zero", data1, 0);

    // Prescale: MTIME_DIV=4 gives mtime=10 after 40 edges.
    do_reset();
    repeat (40) step();
    drive(0, 1, 1, 0, A_TIME, 8'h00, 0);
    step();
    check("pre_mtime40", data4, 64'd10);
    drive(0, 1, 0, 1, A_TIME, 8'hFF, 64'h100);
    step();
    check("pre_store_valid", valid4, 1);
    check("pre_store_data", data4, 0);
    // Edges S+1..S+4 read 0x100 because the tick at S+4 lands after the read.
    // Edge S+5 reads 0x101.
    drive(0, 1, 1, 0, A_TIME, 8'h00, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("pre_phase%0d", i), data4,
            (i == 5) ? 64'h101 : 64'h100);
    end
    idle();

    // Timer interrupt: mtimecmp=20 stored at edge 5.
    do_reset();
    repeat (4) step();
    drive(1, 0, 0, 1, A_CMP, 8'hFF, 64'd20);
    step();
    idle();
    repeat (14) step();
    step();
    check("mtip_before", mtip1, 0);
    step();
    check("mtip_rise", mtip1, 1);
    drive(1, 0, 0, 1, A_CMP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("mtip_still", mtip1, 1);
    idle();
    step();
    check("mtip_clear", mtip1, 0);

    // Masked write into mtimecmp, which is all ones at this point.
    drive(1, 0, 0, 1, A_CMP, 8'h0F, 64'h1122_3344_5566_7788);
    step();
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("mask_cmp", data1, 64'hFFFF_FFFF_5566_7788);

    // Software interrupt.
    drive(1, 0, 0, 1, A_MSIP, 8'hFF, 64'd1);
    step();
    check("msip_set", msip1, 1);
    drive(1, 0, 0, 1, A_MSIP, 8'hFF, 64'd0);
    step();
    check("msip_clr", msip1, 0);

    // Unmapped offset: a store has no effect and a load returns zero.
    drive(1, 0, 0, 1, A_UNM, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(1, 0, 1, 0, A_UNM, 8'h00, 0);
    step();
    check("unm_valid", valid1, 1);
    check("unm_data", data1, 0);
    check("unm_msip", msip1, 0);
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("unm_cmp_kept", data1, 64'hFFFF_FFFF_5566_7788);

    // Protocol: back-to-back load, store, load.
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("b2b_v1", valid1, 1);
    check("b2b_d1", data1, 64'hFFFF_FFFF_5566_7788);
    drive(1, 0, 0, 1, A_CMP, 8'hFF, 64'h0000_1234_5678_9ABC);
    step();
    check("b2b_v2", valid1, 1);
    check("b2b_d2", data1, 0);
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("b2b_v3", valid1, 1);
    check("b2b_d3", data1, 64'h0000_1234_5678_9ABC);

    // Requests without clint_ena: no response and no state change.
    drive(0, 0, 1, 1, A_CMP, 8'hFF, 64'd0);
    step();
    check("noena_valid", valid1, 0);
    check("noena_data", data1, 0);
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("noena_cmp", data1, 64'h0000_1234_5678_9ABC);

    // Combined read+write acts as a store and returns zero data.
    drive(1, 0, 1, 1, A_MSIP, 8'hFF, 64'hAAAA_0000_0000_0001);
    step();
    check("rw_valid", valid1, 1);
    check("rw_data", data1, 0);
    check("rw_msip", msip1, 1);

    // A store with mask 8'h00 still responds but changes nothing.
    drive(1, 0, 0, 1, A_CMP, 8'h00, 64'd0);
    step();
    check("m0_valid", valid1, 1);
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("m0_cmp", data1, 64'h0000_1234_5678_9ABC);

    // Wrap: mtime goes FF..FE, then FF..FF, then 0.
    drive(1, 0, 0, 1, A_TIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    drive(1, 0, 1, 0, A_TIME, 8'h00, 0);
    step();
    check("wrap0", data1, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check("wrap1", data1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("wrap2", data1, 64'd0);

    // Reset during a request: no write and no response.
    drive(1, 0, 0, 1, A_CMP, 8'hFF, 64'd5);
    rst = 1'b1;
    step();
    check("rstreq_valid", valid1, 0);
    rst = 1'b0;
    idle();
    step();
    check("rstreq_valid_next", valid1, 0);
    drive(1, 0, 1, 0, A_CMP, 8'h00, 0);
    step();
    check("rstreq_cmp", data1, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
